// File: rtl/cft_pkg.sv
// ---------------------------------------------------------------------------
// cft_pkg
// Shared types and constants for the datapath stages that sit on the
// internal bus (PC, IR, flags).
//
// Contents:
//   word_t        16-bit machine word / ibus width
//   WORD_BITS     width of word_t
//   PAGE_BITS     number of PC MSBs forming the page handed to the AGL
//   RESET_VECTOR  PC value after reset
//   page_of()     returns the page bits of a word
// ---------------------------------------------------------------------------
package cft_pkg;

  localparam int WORD_BITS = 16;
  localparam int PAGE_BITS = 6;

  typedef logic [WORD_BITS-1:0] word_t;
  typedef logic [PAGE_BITS-1:0] page_t;

  localparam word_t RESET_VECTOR = 16'h0000;

  // The page is the top PAGE_BITS of a word; the AGL concatenates it with
  // IR[9:0] to form page-local operand addresses.
  function automatic page_t page_of(input word_t w);
    return w[WORD_BITS-1 -: PAGE_BITS];
  endfunction

endpackage : cft_pkg

// File: rtl/pc_unit_rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
// 1-bit registered rising-edge detector. The previous sample resets to 1,
// so a signal that is already high (or goes high) straight out of reset is
// never reported as a rise, and a low->high transition spanning a reset is
// discarded.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset (previous sample -> 1)
//   d      in   signal to watch; must meet setup to clk (no synchronizer)
//   q      out  previous sample of d (registered copy)
//   rise   out  combinational: q==0 && d==1, i.e. the edge about to happen
//                latches a 0->1 transition
// ---------------------------------------------------------------------------
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b1;
    end else begin
      q <= d;
    end
  end

  assign rise = ~q & d;

endmodule : rise_detect

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter stage. Holds the PC, which microcode can load from ibus or
// increment, drives the PC back onto ibus on request, and latches the PC page
// at each end-of-instruction for the address generation logic (AGL).
//
// Parameters:
//   WIDTH         PC / ibus width
//   PAGE_BITS     number of PC MSBs latched as the page
//   RESET_VECTOR  PC value after reset
//
// Ports:
//   clk        in     system clock, all state changes on rising edge
//   reset      in     asynchronous, active-high reset
//   ibus       inout  internal bus; driven with pc while nread_pc=0, else Z
//   nread_pc   in     active-low, drive pc onto ibus (combinational)
//   nwrite_pc  in     active-low, load ibus into pc at next edge
//   incpc      in     active-high, increment pc at next edge
//   nend       in     active-low end-of-instruction strobe (sync to clk)
//   pc         out    current PC (registered)
//   pc_page    out    page latched at the last end-of-instruction
//   pc_wrap    out    sticky flag, set when an increment wraps to zero
//
// Control protocol: there is no valid/ready handshake here. Every control
// is a level sampled at each rising edge and acted on in that same edge;
// the block can never stall, so microcode needs no acknowledge. Load wins
// over increment, increment wins over hold.
// ---------------------------------------------------------------------------
module pc_unit
  import cft_pkg::*;
#(
  parameter int                 WIDTH        = WORD_BITS,
  parameter int                 PAGE_BITS    = cft_pkg::PAGE_BITS,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = cft_pkg::RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  reset,
  inout  wire  [WIDTH-1:0]      ibus,
  input  logic                  nread_pc,
  input  logic                  nwrite_pc,
  input  logic                  incpc,
  input  logic                  nend,
  output logic [WIDTH-1:0]      pc,
  output logic [PAGE_BITS-1:0]  pc_page,
  output logic                  pc_wrap
);

  localparam logic [PAGE_BITS-1:0] RESET_PAGE = RESET_VECTOR[WIDTH-1 -: PAGE_BITS];

  logic [WIDTH-1:0]     pc_q;
  logic [WIDTH-1:0]     pc_next;
  logic                 wrap_q;
  logic                 wrap_next;
  logic [PAGE_BITS-1:0] page_q;
  logic                 nend_q;
  logic                 end_rise;

  // -------------------------------------------------------------------------
  // End-of-instruction edge detection. nend_q is the registered nend; a rise
  // is nend_q=0 with nend=1 at the sampling edge.
  // -------------------------------------------------------------------------
  rise_detect u_end_detect (
    .clk   (clk),
    .reset (reset),
    .d     (nend),
    .q     (nend_q),
    .rise  (end_rise)
  );

  // -------------------------------------------------------------------------
  // Next-state for PC and wrap flag.
  // When nread_pc and nwrite_pc are both low (illegal microcode) ibus carries
  // our own pc, so the load simply reloads the current value and clears wrap.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_next   = pc_q;
    wrap_next = wrap_q;
    if (!nwrite_pc) begin
      pc_next   = ibus;
      wrap_next = 1'b0;
    end else if (incpc) begin
      pc_next = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
      if (&pc_q) begin
        wrap_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_next;
      wrap_q <= wrap_next;
    end
  end

  // -------------------------------------------------------------------------
  // Page register. Captures the pre-update PC: the value visible during the
  // cycle nend went high, even if the same edge loads or increments the PC.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q <= RESET_PAGE;
    end else if (end_rise) begin
      page_q <= pc_q[WIDTH-1 -: PAGE_BITS];
    end
  end

  // -------------------------------------------------------------------------
  // Tri-state driver, purely combinational from nread_pc.
  // -------------------------------------------------------------------------
  assign ibus = nread_pc ? {WIDTH{1'bz}} : pc_q;

  assign pc      = pc_q;
  assign pc_page = page_q;
  assign pc_wrap = wrap_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Directed table of load/increment/end vectors with hand-computed results,
// hand-written sequences for reset, ibus drive/release, illegal read+write
// and reset spanning an end strobe, then a random run against a small
// reference model.
// ---------------------------------------------------------------------------
module tb_pc_unit;
  import cft_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  wire  [15:0] ibus;
  logic        nread_pc;
  logic        nwrite_pc;
  logic        incpc;
  logic        nend;
  logic [15:0] pc;
  logic [5:0]  pc_page;
  logic        pc_wrap;

  logic        drv_en;
  logic [15:0] drv_val;

  assign ibus = drv_en ? drv_val : 16'hzzzz;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .ibus      (ibus),
    .nread_pc  (nread_pc),
    .nwrite_pc (nwrite_pc),
    .incpc     (incpc),
    .nend      (nend),
    .pc        (pc),
    .pc_page   (pc_page),
    .pc_wrap   (pc_wrap)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (random phase) ----------------
  word_t m_pc;
  page_t m_page;
  logic  m_wrap;
  logic  m_nq;

  // Evaluates the edge about to happen from the currently applied inputs.
  task automatic model_edge();
    word_t nxt;
    logic  nw;
    nxt = m_pc;
    nw  = m_wrap;
    if (!nwrite_pc) begin
      nxt = nread_pc ? drv_val : m_pc;
      nw  = 1'b0;
    end else if (incpc) begin
      nxt = m_pc + 16'h0001;
      if (m_pc == 16'hFFFF) nw = 1'b1;
    end
    if (!m_nq && nend) m_page = page_of(m_pc);
    m_nq   = nend;
    m_pc   = nxt;
    m_wrap = nw;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic nw, input logic inc, input logic ne, input logic [15:0] val);
    nread_pc  = 1'b1;
    nwrite_pc = nw;
    incpc     = inc;
    nend      = ne;
    drv_en    = ~nw;
    drv_val   = val;
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check async response, release mid-cycle.
  task automatic apply_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_rst_pc"},   pc, 16'h0000);
    check({tag, "_rst_page"}, {10'd0, pc_page}, 16'h0000);
    check({tag, "_rst_wrap"}, {15'd0, pc_wrap}, 16'h0000);
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        nw;
    logic        inc;
    logic        ne;
    logic [15:0] bus;
    logic [15:0] exp_pc;
    logic [5:0]  exp_page;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int timeout_guard;
    timeout_guard = 0;

    // Table: starts right after reset (pc=0000, page=00, nend_q=1).
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'hA5C3, 16'hA5C3, 6'h00, 1'b0}; // load
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'hA5C4, 6'h00, 1'b0}; // inc
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h0400, 16'h0400, 6'h00, 1'b0}; // load beats inc
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'hFFFE, 16'hFFFE, 6'h00, 1'b0}; // load, nend low
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 6'h3F, 1'b0}; // rise: page of FFFE
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 6'h3F, 1'b1}; // wrap
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 6'h3F, 1'b1}; // hold, nend low
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 6'h00, 1'b1}; // rise: page of 0000
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h1234, 16'h1234, 6'h00, 1'b0}; // load clears wrap
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'hFBFF, 16'hFBFF, 6'h00, 1'b0}; // load, nend low
    vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'hFC00, 6'h3E, 1'b0}; // rise + inc: page of FBFF
    vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'hFC00, 6'h3E, 1'b0}; // held high: no latch
    vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'hFC00, 6'h3E, 1'b0}; // low: no latch
    vecs[13] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'hFC00, 6'h3F, 1'b0}; // rise: page of FC00
    vecs[14] = '{1'b1, 1'b1, 1'b1, 16'h0000, 16'hFC01, 6'h3F, 1'b0}; // held high, inc

    // ---- reset state, before any clock edge ----
    reset = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 16'h0000);
    #1;
    check("reset_pc",   pc, 16'h0000);
    check("reset_page", {10'd0, pc_page}, 16'h0000);
    check("reset_wrap", {15'd0, pc_wrap}, 16'h0000);
    // Bus must be released: our own drive has to come through unchanged.
    drv_en  = 1'b1;
    drv_val = 16'h5A5A;
    #1;
    check("reset_ibus_released", ibus, 16'h5A5A);
    drv_en = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;

    // ---- table ----
    for (int i = 0; i < 15; i++) begin
      set_in(vecs[i].nw, vecs[i].inc, vecs[i].ne, vecs[i].bus);
      cycle();
      check($sformatf("vec%0d_pc", i),   pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_page", i), {10'd0, pc_page}, {10'd0, vecs[i].exp_page});
      check($sformatf("vec%0d_wrap", i), {15'd0, pc_wrap}, {15'd0, vecs[i].exp_wrap});
    end
    set_in(1'b1, 1'b0, 1'b1, 16'h0000);

    // ---- ibus drive / release within one cycle (pc = FC01) ----
    nread_pc = 1'b0;
    #1;
    check("ibus_read", ibus, 16'hFC01);
    nread_pc = 1'b1;
    drv_en   = 1'b1;
    drv_val  = 16'h5A5A;
    #1;
    check("ibus_release", ibus, 16'h5A5A);
    drv_en = 1'b0;

    // ---- illegal read+write: pc reloads itself, wrap clears ----
    set_in(1'b0, 1'b0, 1'b1, 16'hFFFF);
    cycle();
    set_in(1'b1, 1'b1, 1'b1, 16'h0000);
    cycle();
    check("wrap_set_pc",   pc, 16'h0000);
    check("wrap_set_flag", {15'd0, pc_wrap}, 16'h0001);
    set_in(1'b1, 1'b1, 1'b1, 16'h0000);
    cycle();
    check("inc_after_wrap_pc", pc, 16'h0001);
    nread_pc  = 1'b0;
    nwrite_pc = 1'b0;
    incpc     = 1'b1;
    drv_en    = 1'b0;
    cycle();
    check("illegal_rw_pc",   pc, 16'h0001);
    check("illegal_rw_wrap", {15'd0, pc_wrap}, 16'h0000);
    set_in(1'b1, 1'b0, 1'b1, 16'h0000);

    // ---- reset spanning an end strobe ----
    set_in(1'b0, 1'b0, 1'b1, 16'hFBFF);
    cycle();
    set_in(1'b1, 1'b0, 1'b0, 16'h0000);
    cycle();                                   // nend_q = 0, no latch yet
    check("pre_rst_page", {10'd0, pc_page}, 16'h003F);
    apply_reset("mid_end");                    // nend still low throughout
    nend = 1'b1;
    cycle();
    check("mid_end_page", {10'd0, pc_page}, 16'h0000);
    check("mid_end_pc",   pc, 16'h0000);
    set_in(1'b1, 1'b1, 1'b1, 16'h0000);
    cycle();
    check("mid_end_page_held", {10'd0, pc_page}, 16'h0000);

    // ---- random run against the model ----
    m_pc   = 16'h0001;
    m_page = 6'h00;
    m_wrap = 1'b0;
    m_nq   = 1'b1;
    for (int n = 0; n < 1024; n++) begin
      int mode;
      logic [15:0] val;
      mode = $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0:       val = 16'hFFFF;
        1:       val = 16'hFFFE;
        2:       val = 16'hFBFF;
        default: val = 16'($urandom_range(0, 65535));
      endcase
      set_in(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), val);
      if (mode < 2) begin
        nwrite_pc = 1'b0;
        drv_en    = 1'b1;
      end else if (mode == 2) begin
        nwrite_pc = 1'b0;
        nread_pc  = 1'b0;
      end else if (mode == 3) begin
        nread_pc = 1'b0;
      end
      if (!nread_pc) begin
        #1;
        check("rnd_ibus", ibus, m_pc);
      end
      model_edge();
      exp_q.push_back(m_pc);
      cycle();
      check("rnd_pc",   pc, exp_q.pop_front());
      check("rnd_page", {10'd0, pc_page}, {10'd0, m_page});
      check("rnd_wrap", {15'd0, pc_wrap}, {15'd0, m_wrap});
      timeout_guard++;
    end
    set_in(1'b1, 1'b0, 1'b1, 16'h0000);

    if (timeout_guard != 1024) begin
      n_cmp++;
      n_err++;
      $display("FAIL random_loop_length: got %0d expected 1024", timeout_guard);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "time limit");
  end

endmodule : tb_pc_unit
